// File: rtl/ctrl_mult_shift_add.sv
// Control sequencer for a shift-add multiplier.
// Issues Load, then Ad/Sh per multiplier bit, then holds Done until St drops.
module ctrl_mult_shift_add #(
    parameter  int N     = 4,
    localparam int CNT_W = $clog2(N)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             St,
    input  logic             M,
    output logic             Load,
    output logic             Sh,
    output logic             Ad,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_inc;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(N - 1));
    assign Count  = r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wrap explicitly so non-power-of-two N still returns to 0
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (r_state == S_LOAD) begin
            r_count <= '0;
        end else if (w_inc) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        Load   = 1'b0;
        Sh     = 1'b0;
        Ad     = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (St) w_next = S_LOAD;
            end
            S_LOAD: begin
                Load   = 1'b1;
                Busy   = 1'b1;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                Busy = 1'b1;
                if (M) begin
                    Ad     = 1'b1;
                    w_next = S_SHIFT;
                end else begin
                    Sh    = 1'b1;
                    w_inc = 1'b1;
                    if (w_last) w_next = S_DONE;
                end
            end
            S_SHIFT: begin
                Busy   = 1'b1;
                Sh     = 1'b1;
                w_inc  = 1'b1;
                w_next = w_last ? S_DONE : S_CHECK;
            end
            S_DONE: begin
                Done = 1'b1;
                if (!St) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_mult_shift_add.sv
// Bench for ctrl_mult_shift_add: drives a behavioural ACC and checks
// per-cycle command streams against a bit-list model of the multiplier.
module tb_ctrl_mult_shift_add;

    localparam int N  = 4;
    localparam int CW = $clog2(N);

    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_LOAD = 5'b10010;
    localparam logic [4:0] V_AD   = 5'b00110;
    localparam logic [4:0] V_SH   = 5'b01010;
    localparam logic [4:0] V_DONE = 5'b00001;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          St = 1'b0;
    logic          M;
    logic          Load, Sh, Ad, Busy, Done;
    logic [CW-1:0] Count;

    logic [2*N:0]  acc = '0;
    logic [N-1:0]  mpl = '0;
    logic [N-1:0]  mcd = '0;
    logic          m_x = 1'b0;
    logic [4:0]    vec;

    int passed = 0;
    int total  = 0;

    ctrl_mult_shift_add #(.N(N)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .St     (St),
        .M      (M),
        .Load   (Load),
        .Sh     (Sh),
        .Ad     (Ad),
        .Busy   (Busy),
        .Done   (Done),
        .Count  (Count)
    );

    always #5 Clk = ~Clk;

    assign M   = m_x ? 1'bx : acc[0];
    assign vec = {Load, Sh, Ad, Busy, Done};

    // Behavioural accumulator responding to the issued commands
    always @(posedge Clk) begin
        if (Load)
            acc <= {{(N+1){1'b0}}, mpl};
        else if (Ad)
            acc[2*N:N] <= acc[2*N:N] + (N+1)'(mcd);
        else if (Sh)
            acc <= acc >> 1;
    end

    task automatic chk_vec(input string nm, input logic [4:0] exp);
        total++;
        if (vec !== exp)
            $display("FAIL %s: {Load,Sh,Ad,Busy,Done} got %b want %b", nm, vec, exp);
        else
            passed++;
    endtask

    task automatic chk_cnt(input string nm, input logic [CW-1:0] exp);
        total++;
        if (Count !== exp)
            $display("FAIL %s: Count got %0d want %0d", nm, Count, exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        St      = 1'b0;
        m_x     = 1'b1;
        #2;
        chk_vec("reset_outputs", V_IDLE);
        chk_cnt("reset_count", '0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk_vec($sformatf("idle_hold_%0d", i), V_IDLE);
            chk_cnt($sformatf("idle_cnt_%0d", i), '0);
        end
        m_x = 1'b0;
    endtask

    task automatic run_mult(input string nm, input logic [N-1:0] a,
                            input logic [N-1:0] b, input bit hold);
        bit q[$];
        int sh = 0;
        logic [2*N-1:0] prod;
        for (int i = 0; i < N; i++) begin
            if (a[i]) q.push_back(1'b1);
            q.push_back(1'b0);
        end
        prod = (2*N)'(a) * (2*N)'(b);
        mpl  = a;
        mcd  = b;
        @(negedge Clk);
        St = 1'b1;
        @(negedge Clk);
        chk_vec({nm, "_load"}, V_LOAD);
        if (!hold) St = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge Clk);
            chk_vec($sformatf("%s_cyc%0d", nm, k + 2), q[k] ? V_AD : V_SH);
            chk_cnt($sformatf("%s_cnt%0d", nm, k + 2), CW'(sh % N));
            if (!q[k]) sh++;
        end
        @(negedge Clk);
        chk_vec({nm, "_done"}, V_DONE);
        chk_cnt({nm, "_done_cnt"}, '0);
        total++;
        if (acc[2*N-1:0] !== prod)
            $display("FAIL %s_product: got %0d want %0d", nm, acc[2*N-1:0], prod);
        else
            passed++;
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge Clk);
                chk_vec($sformatf("%s_hold%0d", nm, i), V_DONE);
            end
            St = 1'b0;
        end
        @(negedge Clk);
        chk_vec({nm, "_idle"}, V_IDLE);
    endtask

    task automatic test_directed();
        run_mult("m1011", 4'b1011, 4'd13, 1'b0);
        run_mult("m0000", 4'b0000, 4'd9, 1'b0);
        run_mult("m1111", 4'b1111, 4'd15, 1'b0);
    endtask

    task automatic test_handshake();
        run_mult("hs", 4'b0110, 4'd7, 1'b1);
        run_mult("hs_restart", 4'b0101, 4'd3, 1'b0);
    endtask

    task automatic test_abort();
        mpl = '0;
        mcd = 4'd5;
        @(negedge Clk);
        St = 1'b1;
        @(negedge Clk);
        chk_vec("abort_load", V_LOAD);
        St = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk_vec($sformatf("abort_sh%0d", k), V_SH);
        end
        #1 Reset_n = 1'b0;
        #1;
        chk_vec("abort_outputs", V_IDLE);
        chk_cnt("abort_count", '0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk_vec($sformatf("abort_idle%0d", i), V_IDLE);
            chk_cnt($sformatf("abort_idle_cnt%0d", i), '0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            run_mult($sformatf("rnd%0d", t), N'($urandom), N'($urandom),
                     bit'($urandom_range(0, 1)));
        end
    endtask

    // Load/Sh/Ad exclusivity is a standing invariant for every cycle
    always @(negedge Clk) begin
        if (Reset_n && ($countones({Load, Sh, Ad}) > 1)) begin
            total++;
            $display("FAIL cmd_exclusive: {Load,Sh,Ad}=%b want at most one high",
                     {Load, Sh, Ad});
        end
    end

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_mult_shift_add.md
Name: ctrl_mult_shift_add

Overview:
- Control unit for the shift-add multiplier. It is the command-issuing end of the accumulator's Load/Sh/Ad interface.
- Sequences one N-bit × N-bit multiplication:
  - issues Load once;
  - then, for each multiplier bit, issues Ad (if the current LSB M=1) followed by Sh, or Sh alone;
  - then signals Done.
- Sits beside the ACC register. M is taken from the ACC output bit 0 (the current multiplier LSB).
- Start/Done form a four-phase handshake with the system.

Parameters:
- N, 4, multiplier operand width in bits (N ≥ 2). The paired ACC is 2N+1 bits wide (9 for N=4).
- CNT_W, $clog2(N), width of the bit counter (derived; do not override).

Ports:
- Clk  input  1  system clock; all state changes on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- St  input  1  start request; sampled on rising edge of Clk
- M  input  1  current multiplier LSB (ACC output bit 0)
- Load  output  1  ACC load command
- Sh  output  1  ACC shift-right command
- Ad  output  1  ACC add command
- Busy  output  1  high while a multiplication is in progress
- Done  output  1  result valid in ACC; part of the handshake
- Count  output  CNT_W  bits processed so far (debug/verification)

Behaviour:
- States: IDLE, LOAD, CHECK, SHIFT, DONE. The state register and Count are reset asynchronously by Reset_n=0.
- Reset:
  - state goes to IDLE and Count to 0 immediately, without waiting for a clock edge;
  - Load, Sh, Ad, Busy and Done are all 0 while Reset_n=0;
  - Reset_n=0 mid-operation aborts the multiplication; no further commands are issued.
- Outputs are combinational decodes of state (and M in CHECK only). Commands are valid for the whole cycle so the ACC samples them at the next rising edge.
- IDLE:
  - all outputs 0;
  - St=1 at a rising edge → LOAD; otherwise stay in IDLE.
- LOAD:
  - Load=1 and Busy=1;
  - Count cleared to 0;
  - next state CHECK unconditionally.
- CHECK:
  - Busy=1.
  - If M=1: Ad=1, next state SHIFT.
  - If M=0: Sh=1 and Count increments.
    - If Count==N-1: next state DONE.
    - Else: stay in CHECK.
- SHIFT:
  - Busy=1, Sh=1, Count increments.
  - If Count==N-1: next state DONE.
  - Else: next state CHECK.
- DONE:
  - Done=1, Busy=0;
  - stay while St=1; go to IDLE on the first edge with St=0.
  - A new start requires St to fall and rise again.
- Invariants:
  - Load, Sh and Ad are mutually exclusive (at most one high in any cycle);
  - Ad is always followed immediately by exactly one Sh;
  - exactly N Sh pulses and popcount(multiplier) Ad pulses per operation.
- Latency:
  - cycle 1 is the first cycle after the edge that sampled St=1 (Load);
  - cycles 2 .. 1+N+popcount hold Ad/Sh;
  - Done rises in cycle 2+N+popcount.
- Count wraps from N-1 to 0 on the final shift. Count holds its value in IDLE and DONE.
- St is ignored while Busy=1. St held high continuously does not retrigger; the block waits in DONE.
- M is don't-care in every state except CHECK. X on M outside CHECK must not propagate to the outputs.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle → all outputs 0 and Count=0 before the next edge; release, hold St=0 for 5 cycles → remains IDLE, all outputs 0.
- Multiplier 4'b1011 (N=4), bench drives M = current ACC LSB per shift → Load in cycle 1; sequence Ad,Sh,Ad,Sh,Sh,Ad,Sh over cycles 2–8; Done=1 in cycle 9; with a real ACC loaded with multiplicand 13, result = 143.
- Multiplier 0 → Load, then 4 consecutive Sh, no Ad; Done in cycle 6.
- Multiplier 4'b1111 → 4 Ad/Sh pairs over cycles 2–9; Done in cycle 10; Load/Sh/Ad never overlap (checked every cycle).
- Handshake: keep St=1 for 4 cycles after Done → Done stays 1 and no new Load is issued; drop St → IDLE next edge; raise St → new Load.
- Abort: pull Reset_n low during the 3rd Sh → outputs 0 immediately; after release with St=0 → IDLE and no commands issued.
